// File: rtl/uart_tx_fifo_gen_if.sv
// rtl/uart_tx_fifo_gen_if.sv - push-side bus of the UART transmitter FIFO
interface uart_tx_fifo_gen_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output wr_en, wr_data,
    input  fifo_full, fifo_empty, fifo_level, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output fifo_full, fifo_empty, fifo_level, overflow
  );
endinterface

// File: rtl/uart_tx_fifo_gen.sv
// rtl/uart_tx_fifo_gen.sv - UART transmitter with transmit FIFO, baud divider and break
module uart_tx_fifo_gen #(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BAUD_W-1:0] baud_val,
  input  logic [1:0]        data_len,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              stop2,
  input  logic              break_en,
  uart_tx_fifo_gen_if.slave wr_if,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, empty_q, overflow_q;
  logic              push, pop, frame_end, tick, counting;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [1:0]        len_q;
  logic              par_en_q, odd_q, stop2_q, par_acc, brk_hold;
  logic              last_bit;

  // Full is the registered flag, so a same-cycle pop never lets an extra push in.
  assign push     = wr_if.wr_en && !full_q;
  assign level_d  = level_q + LW'(push) - LW'(pop);
  assign counting = (state_q != S_IDLE) && (state_q != S_BREAK);
  assign tick     = counting && (baud_cnt == baud_val);
  assign last_bit = (bit_cnt == ({1'b0, len_q} + 3'd4));

  assign wr_if.fifo_full  = full_q;
  assign wr_if.fifo_empty = empty_q;
  assign wr_if.fifo_level = level_q;
  assign wr_if.overflow   = overflow_q;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_if.wr_data;
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH_L);
      empty_q    <= (level_d == '0);
      overflow_q <= wr_if.wr_en && full_q;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and FIFO pop decision
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (break_en) begin
          state_d = S_BREAK;
        end else if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && last_bit) state_d = par_en_q ? S_PARITY : S_STOP1;
      S_PARITY: if (tick) state_d = S_STOP1;
      S_STOP1: begin
        if (tick) begin
          if (brk_hold)     state_d = S_IDLE;
          else if (stop2_q) state_d = S_STOP2;
          else              frame_end = 1'b1;
        end
      end
      S_STOP2:  if (tick) frame_end = 1'b1;
      S_BREAK:  if (!break_en) state_d = S_STOP1;
      default:  state_d = S_IDLE;
    endcase
    // Chain straight into the next start bit when more data is waiting.
    if (frame_end) begin
      if (!break_en && !empty_q) begin
        pop     = 1'b1;
        state_d = S_START;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Bit-period counter, parked at zero while the line is not framing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                baud_cnt <= '0;
    else if (!counting || tick)  baud_cnt <= '0;
    else                         baud_cnt <= baud_cnt + BAUD_W'(1);
  end

  // Character load, shifting, running parity and break-recovery marker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      len_q    <= '0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      stop2_q  <= 1'b0;
      par_acc  <= 1'b0;
      brk_hold <= 1'b0;
    end else begin
      if (pop) begin
        shreg    <= mem[rd_ptr];
        bit_cnt  <= '0;
        len_q    <= data_len;
        par_en_q <= parity_en;
        odd_q    <= odd_n_even;
        stop2_q  <= stop2;
        par_acc  <= 1'b0;
      end else if (state_q == S_DATA && tick) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        par_acc <= par_acc ^ shreg[0];
      end
      if (state_q == S_BREAK && !break_en)    brk_hold <= 1'b1;
      else if (state_q == S_STOP1 && tick)    brk_hold <= 1'b0;
    end
  end

  // Registered line and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      case (state_q)
        S_START:  tx <= 1'b0;
        S_DATA:   tx <= shreg[0];
        S_PARITY: tx <= par_acc ^ odd_q;
        S_BREAK:  tx <= 1'b0;
        default:  tx <= 1'b1;
      endcase
      tx_busy <= counting;
      tx_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// tb/tb_uart_tx_fifo_gen.sv - directed scoreboard bench for uart_tx_fifo_gen
module tb_uart_tx_fifo_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] baud_val;
  logic [1:0]  data_len;
  logic        parity_en, odd_n_even, stop2, break_en;
  logic        tx_busy, tx_done, tx;

  int n_run  = 0;
  int n_fail = 0;
  int last_wait;
  logic exp_bits_q[$];
  int   frm_len_q[$];

  uart_tx_fifo_gen_if #(.FIFO_DEPTH(16)) wif();

  uart_tx_fifo_gen #(.FIFO_DEPTH(16), .BAUD_W(13)) dut (
    .clk(clk), .reset_n(reset_n), .baud_val(baud_val), .data_len(data_len),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .stop2(stop2),
    .break_en(break_en), .wr_if(wif), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the push happens on the following posedge.
  task automatic wr(input logic [7:0] d);
    wif.wr_en   = 1'b1;
    wif.wr_data = d;
    @(negedge clk);
    wif.wr_en   = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int nb, input bit pe,
                              input bit odd, input bit s2);
    logic p;
    p = odd;
    exp_bits_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_bits_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) exp_bits_q.push_back(p);
    exp_bits_q.push_back(1'b1);
    if (s2) exp_bits_q.push_back(1'b1);
    frm_len_q.push_back(2 + nb + int'(pe) + int'(s2));
  endtask

  // Waits for a start bit, then checks every clock of the frame against the scoreboard.
  task automatic check_frame(input string tag, input int baud);
    int   w;
    int   n;
    logic b;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx !== 1'b0 && w < 500);
    last_wait = w;
    n = frm_len_q.pop_front();
    if (tx !== 1'b0) begin
      chk({tag, " start timeout"}, 32'(tx), 0);
      for (int i = 0; i < n; i++) b = exp_bits_q.pop_front();
      return;
    end
    for (int i = 0; i < n; i++) begin
      b = exp_bits_q.pop_front();
      for (int c = 0; c <= baud; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        chk($sformatf("%s tx bit%0d clk%0d", tag, i, c), 32'(tx), 32'(b));
        chk($sformatf("%s tx_done bit%0d clk%0d", tag, i, c), 32'(tx_done),
            (i == n - 1 && c == baud) ? 1 : 0);
      end
    end
  endtask

  initial begin
    logic [7:0] bytes [17];
    int bad;
    reset_n = 1'b0; baud_val = 13'd3; data_len = 2'b11; parity_en = 1'b0;
    odd_n_even = 1'b0; stop2 = 1'b0; break_en = 1'b0;
    wif.wr_en = 1'b0; wif.wr_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 1);
    chk("rst fifo_empty", 32'(wif.fifo_empty), 1);
    chk("rst fifo_full", 32'(wif.fifo_full), 0);
    chk("rst fifo_level", 32'(wif.fifo_level), 0);
    chk("rst overflow", 32'(wif.overflow), 0);
    chk("rst tx_busy", 32'(tx_busy), 0);
    chk("rst tx_done", 32'(tx_done), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, baud_val=3, 0xA5 with latency check
    expect_frame(8'hA5, 8, 0, 0, 0);
    wr(8'hA5);
    chk("a5 fifo_empty after push", 32'(wif.fifo_empty), 0);
    chk("a5 fifo_level after push", 32'(wif.fifo_level), 1);
    check_frame("a5", 3);
    chk("a5 start latency", 32'(last_wait), 2);
    @(negedge clk);
    chk("a5 tx_busy after frame", 32'(tx_busy), 0);
    chk("a5 fifo_empty after frame", 32'(wif.fifo_empty), 1);

    // 7-bit, even then odd parity, two stop bits
    baud_val = 13'd2; data_len = 2'b10; parity_en = 1'b1; stop2 = 1'b1;
    odd_n_even = 1'b0;
    expect_frame(8'h35, 7, 1, 0, 1);
    wr(8'h35);
    check_frame("35 even", 2);
    @(negedge clk);
    odd_n_even = 1'b1;
    expect_frame(8'h35, 7, 1, 1, 1);
    wr(8'h35);
    check_frame("35 odd", 2);
    @(negedge clk);

    // baud_val=0, 5-bit 0x1F
    baud_val = 13'd0; data_len = 2'b00; parity_en = 1'b0; stop2 = 1'b0;
    odd_n_even = 1'b0;
    expect_frame(8'h1F, 5, 0, 0, 0);
    wr(8'h1F);
    check_frame("1f baud0", 0);
    repeat (2) @(negedge clk);

    // Break held while filling past capacity
    baud_val = 13'd3; data_len = 2'b11;
    break_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("brk tx low", 32'(tx), 0);
    chk("brk tx_busy", 32'(tx_busy), 0);
    for (int i = 0; i < 17; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      if (i < 16) expect_frame(bytes[i], 8, 0, 0, 0);
      wr(bytes[i]);
      chk($sformatf("brk tx low push%0d", i), 32'(tx), 0);
      chk($sformatf("brk level push%0d", i), 32'(wif.fifo_level), (i < 16) ? i + 1 : 16);
      chk($sformatf("brk overflow push%0d", i), 32'(wif.overflow), (i == 16) ? 1 : 0);
      if (i == 15) chk("brk full at 16", 32'(wif.fifo_full), 1);
    end
    @(negedge clk);
    chk("brk overflow one cycle", 32'(wif.overflow), 0);
    chk("brk full held", 32'(wif.fifo_full), 1);
    chk("brk tx still low", 32'(tx), 0);

    // Release: one stop-level bit period, then 16 back-to-back frames
    break_en = 1'b0;
    @(negedge clk);
    chk("rel tx low", 32'(tx), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rel idle bit clk%0d", c), 32'(tx), 1);
      chk($sformatf("rel tx_done clk%0d", c), 32'(tx_done), 0);
    end
    for (int f = 0; f < 16; f++) begin
      check_frame($sformatf("b2b%0d", f), 3);
      chk($sformatf("b2b%0d gap", f), 32'(last_wait), (f == 0) ? 2 : 1);
    end
    chk("b2b fifo_empty", 32'(wif.fifo_empty), 1);
    chk("b2b busy at last done", 32'(tx_busy), 1);
    @(negedge clk);
    chk("b2b busy dropped", 32'(tx_busy), 0);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("b2b no 17th frame", 32'(bad), 0);

    // Reset mid data bit
    wr(8'h00);
    wr(8'h55);
    repeat (10) @(negedge clk);
    chk("mid pre-reset tx low", 32'(tx), 0);
    reset_n = 1'b0;
    #1;
    chk("mid rst tx", 32'(tx), 1);
    chk("mid rst tx_busy", 32'(tx_busy), 0);
    chk("mid rst fifo_empty", 32'(wif.fifo_empty), 1);
    chk("mid rst fifo_level", 32'(wif.fifo_level), 0);
    exp_bits_q.delete();
    frm_len_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("mid quiet after reset", 32'(bad), 0);
    expect_frame(8'hC3, 8, 0, 0, 0);
    wr(8'hC3);
    check_frame("c3 after reset", 3);
    chk("c3 start latency", 32'(last_wait), 2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
